i2c_target_rx: RTL and testbench
================================

Name: i2c_target_rx

Overview:
Write-only I2C target (responder) that sits at the far end of the bit-banged SCL/SDA bus driven by i2c_emulator. It stands in for the SSD1306 display in simulation and on the FPGA. It samples the bus with the system clock, detects START/STOP, matches the 7-bit address, ACKs by pulling SDA low, and delivers each received byte to downstream logic over a valid/ready handshake.

Parameters:
TARGET_ADDR, 7'h3C, 7-bit I2C address this block responds to.
FILTER_LEN, 3, consecutive equal samples required by the optional deglitcher (range 2..8).

Ports:
clk  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous active-low reset
scl_in  input  1  bus SCL level, asynchronous to clk
sda_in  input  1  bus SDA level, asynchronous to clk
sda_oe  output  1  1 = drive SDA low (ACK); 0 = release (open-drain)
rx_ready  input  1  downstream can accept a byte
rx_data  output  8  last received data byte, MSB first on the wire
rx_valid  output  1  one-cycle pulse, rx_data valid
rx_first  output  1  qualifies rx_valid: first data byte after the address
busy  output  1  addressed transaction in progress
start_det  output  1  one-cycle pulse per START or repeated START
stop_det  output  1  one-cycle pulse per STOP

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low. On reset all outputs are 0, rx_data is 8'h00, and the FSM goes to IDLE. Reset asserted mid-ACK releases sda_oe immediately.
- Input sync: scl_in and sda_in each pass through a 2-FF synchronizer, then a registered previous-value stage for edge detect. Bus-to-internal latency is 3 clk.
- START: SDA falls while SCL is high. Pulse start_det, clear the bit counter, go to ADDR. This applies from any state, including mid-byte (repeated START aborts that byte with no rx_valid).
- STOP: SDA rises while SCL is high. Pulse stop_det, go to IDLE, clear busy and sda_oe. Applies from any state.
- Bits are sampled on SCL rising edges only. The shift register shifts left, MSB first. The bit counter runs 0..7.
- States:
  - IDLE: ignore SCL edges.
  - ADDR: collect 8 bits. Then:
    - {addr[7:1]==TARGET_ADDR, R/W=0}: go to ADDR_ACK, set busy, set rx_first flag.
    - Address mismatch or R/W=1: go to IGNORE (NACK; reads are not supported).
  - ADDR_ACK: on the next SCL falling edge assert sda_oe. On the following SCL falling edge (end of the 9th clock) deassert it and go to DATA.
  - DATA: collect 8 bits. On the SCL falling edge after bit 8:
    - rx_ready=1: latch rx_data, pulse rx_valid for 1 clk with rx_first=flag, clear flag, assert sda_oe, go to DATA_ACK.
    - rx_ready=0: byte is dropped, no rx_valid, sda_oe stays 0 (NACK), go to IGNORE.
  - DATA_ACK: release sda_oe on the next SCL falling edge, reset the bit counter, return to DATA.
  - IGNORE: sda_oe=0, busy=0. Leave only on START or STOP.
- rx_first is 0 whenever rx_valid is 0.
- sda_oe changes only on SCL falling edges, START/STOP, or reset. It never changes while SCL is high.
- Simultaneous SCL and SDA change in the same sample: SCL edge processing takes priority, and no START/STOP is flagged for that sample.
- No clock stretching. SCL is never driven.

Optional Feature:
Macro I2C_TARGET_DEGLITCH_EN.
- Defined: after synchronization, each line passes through a filter. The filter updates its output only after FILTER_LEN consecutive identical samples, which rejects pulses shorter than FILTER_LEN clk. Latency becomes 3+FILTER_LEN clk.
- Undefined: no filter. Latency is 3 clk, and FILTER_LEN is unused.

Test Plan:
- START, 0x78, 0x00, 0xAF, STOP with rx_ready=1 -> ACK on all three 9th clocks; rx_valid twice: (0x00, rx_first=1), then (0xAF, rx_first=0); start_det and stop_det pulse once each; busy falls after STOP.
- START, 0x7A (address 0x3D), 0x55, STOP -> sda_oe stays 0 throughout, no rx_valid, busy stays 0.
- START, 0x79 (read of 0x3C) -> NACK, IGNORE state, no rx_valid until STOP.
- START, 0x78, then 0x12 sent with rx_ready=0 -> address ACKed, data NACKed, no rx_valid; a following 0x34 byte is also ignored until the next START.
- START, 0x78, 4 bits of a data byte, repeated START, 0x78, 0xC3, STOP -> two start_det pulses, exactly one rx_valid (0xC3, rx_first=1).
- reset_n pulled low during the ACK of 0x78 -> sda_oe=0 within the same cycle and all outputs at reset values. With I2C_TARGET_DEGLITCH_EN defined, a 1-clk SDA glitch while SCL is high produces no start_det or stop_det.

Source files
------------

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: write-only I2C target. It samples SCL/SDA on clk, detects START/STOP,
// matches a 7-bit address, ACKs by pulling SDA low, and hands each data byte downstream
// over a valid/ready handshake. Reads are NACKed.
// Optional build macro: I2C_TARGET_DEGLITCH_EN adds a FILTER_LEN-sample deglitcher per line.
module i2c_target_rx #(
  parameter logic [6:0]  TARGET_ADDR = 7'h3C,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_DATA     = 3'd3,
    S_DATA_ACK = 3'd4,
    S_IGNORE   = 3'd5
  } state_t;

  // The deglitch length is only meaningful in 2..8; reject anything else at elaboration
  if (FILTER_LEN < 2 || FILTER_LEN > 8) begin : g_bad_filter_len
    $error("i2c_target_rx: FILTER_LEN must be in 2..8");
  end

  // Synchronizer and edge-detect registers (reset to the idle-high bus level)
  logic [1:0]        r_scl_sync;
  logic [1:0]        r_sda_sync;
  logic              r_scl_prev;
  logic              r_sda_prev;
  logic              w_scl;
  logic              w_sda;

  // FSM and datapath registers
  state_t            r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [BYTE_W-1:0] r_shift;
  logic              r_full;
  logic              r_first_flag;
  logic              r_sda_oe;
  logic              r_busy;
  logic [BYTE_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_rx_first;
  logic              r_start_det;
  logic              r_stop_det;

  // Next-state values
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_bit_cnt_nxt;
  logic [BYTE_W-1:0] w_shift_nxt;
  logic              w_full_nxt;
  logic              w_first_flag_nxt;
  logic              w_sda_oe_nxt;
  logic              w_busy_nxt;
  logic [BYTE_W-1:0] w_rx_data_nxt;
  logic              w_rx_valid_nxt;
  logic              w_rx_first_nxt;
  logic              w_start_det_nxt;
  logic              w_stop_det_nxt;

  // Bus events
  logic              w_scl_rise;
  logic              w_scl_fall;
  logic              w_start;
  logic              w_stop;

  // Two-flop synchronizers for the asynchronous bus lines
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
    end
  end

`ifdef I2C_TARGET_DEGLITCH_EN
  localparam int unsigned FLT_CW = 4;

  logic              r_scl_flt;
  logic              r_sda_flt;
  logic [FLT_CW-1:0] r_scl_fcnt;
  logic [FLT_CW-1:0] r_sda_fcnt;

  // Output follows a line only after FILTER_LEN consecutive samples disagree with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_flt  <= 1'b1;
      r_sda_flt  <= 1'b1;
      r_scl_fcnt <= '0;
      r_sda_fcnt <= '0;
    end else begin
      if (r_scl_sync[1] == r_scl_flt) begin
        r_scl_fcnt <= '0;
      end else if (r_scl_fcnt == FLT_CW'(FILTER_LEN - 1)) begin
        r_scl_flt  <= r_scl_sync[1];
        r_scl_fcnt <= '0;
      end else begin
        r_scl_fcnt <= r_scl_fcnt + FLT_CW'(1);
      end
      if (r_sda_sync[1] == r_sda_flt) begin
        r_sda_fcnt <= '0;
      end else if (r_sda_fcnt == FLT_CW'(FILTER_LEN - 1)) begin
        r_sda_flt  <= r_sda_sync[1];
        r_sda_fcnt <= '0;
      end else begin
        r_sda_fcnt <= r_sda_fcnt + FLT_CW'(1);
      end
    end
  end

  assign w_scl = r_scl_flt;
  assign w_sda = r_sda_flt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  // Previous-sample stage for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  // START/STOP need SCL high in both samples, so an SCL edge in the same sample wins
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = w_scl & r_scl_prev & ~w_sda & r_sda_prev;
  assign w_stop     = w_scl & r_scl_prev & w_sda & ~r_sda_prev;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_full       <= 1'b0;
      r_first_flag <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_busy       <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_first   <= 1'b0;
      r_start_det  <= 1'b0;
      r_stop_det   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_full       <= w_full_nxt;
      r_first_flag <= w_first_flag_nxt;
      r_sda_oe     <= w_sda_oe_nxt;
      r_busy       <= w_busy_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_rx_first   <= w_rx_first_nxt;
      r_start_det  <= w_start_det_nxt;
      r_stop_det   <= w_stop_det_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_full_nxt       = r_full;
    w_first_flag_nxt = r_first_flag;
    w_sda_oe_nxt     = r_sda_oe;
    w_busy_nxt       = r_busy;
    w_rx_data_nxt    = r_rx_data;
    w_rx_valid_nxt   = 1'b0;
    w_rx_first_nxt   = 1'b0;
    w_start_det_nxt  = 1'b0;
    w_stop_det_nxt   = 1'b0;

    if (w_start) begin
      w_start_det_nxt = 1'b1;
      w_state_nxt     = S_ADDR;
      w_bit_cnt_nxt   = '0;
      w_full_nxt      = 1'b0;
      w_sda_oe_nxt    = 1'b0;
    end else if (w_stop) begin
      w_stop_det_nxt   = 1'b1;
      w_state_nxt      = S_IDLE;
      w_bit_cnt_nxt    = '0;
      w_full_nxt       = 1'b0;
      w_first_flag_nxt = 1'b0;
      w_busy_nxt       = 1'b0;
      w_sda_oe_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
        end

        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[BYTE_W-2:0], w_sda};
            if (r_bit_cnt == CNT_W'(7)) begin
              w_bit_cnt_nxt = '0;
              // Address lives in the 7 bits already shifted in; the current bit is R/W
              if (r_shift[6:0] == TARGET_ADDR && !w_sda) begin
                w_state_nxt      = S_ADDR_ACK;
                w_busy_nxt       = 1'b1;
                w_first_flag_nxt = 1'b1;
              end else begin
                w_state_nxt = S_IGNORE;
                w_busy_nxt  = 1'b0;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            end
          end
        end

        S_ADDR_ACK: begin
          // First falling edge drives the ACK, the second (end of 9th clock) releases it
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt  = 1'b0;
              w_state_nxt   = S_DATA;
              w_bit_cnt_nxt = '0;
              w_full_nxt    = 1'b0;
            end
          end
        end

        S_DATA: begin
          if (w_scl_rise && !r_full) begin
            w_shift_nxt = {r_shift[BYTE_W-2:0], w_sda};
            if (r_bit_cnt == CNT_W'(7)) begin
              w_bit_cnt_nxt = '0;
              w_full_nxt    = 1'b1;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            end
          end else if (w_scl_fall && r_full) begin
            w_full_nxt = 1'b0;
            if (rx_ready) begin
              w_rx_data_nxt    = r_shift;
              w_rx_valid_nxt   = 1'b1;
              w_rx_first_nxt   = r_first_flag;
              w_first_flag_nxt = 1'b0;
              w_sda_oe_nxt     = 1'b1;
              w_state_nxt      = S_DATA_ACK;
            end else begin
              w_state_nxt = S_IGNORE;
              w_busy_nxt  = 1'b0;
            end
          end
        end

        S_DATA_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt  = 1'b0;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_DATA;
          end
        end

        S_IGNORE: begin
          w_sda_oe_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end

        default: begin
          w_state_nxt  = S_IDLE;
          w_sda_oe_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe    = r_sda_oe;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_first  = r_rx_first;
  assign busy      = r_busy;
  assign start_det = r_start_det;
  assign stop_det  = r_stop_det;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Testbench for i2c_target_rx: bit-banged I2C master, pulse monitor and a
// transaction-level model of which bytes are ACKed and delivered.
module tb_i2c_target_rx;

  localparam int unsigned Q = 4;   // clk cycles per quarter of an SCL bit

  logic       clk;
  logic       reset_n;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       rx_ready;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       busy;
  logic       start_det;
  logic       stop_det;

  int n_cmp = 0;
  int n_err = 0;

  // Open-drain bus: either side can pull SDA low
  assign sda_bus = sda_m & ~sda_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2c_target_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl_m),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_first  (rx_first),
    .busy      (busy),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Monitor: log delivered bytes and count pulses (only this block writes these)
  int         start_cnt = 0;
  int         stop_cnt  = 0;
  int         bad_first = 0;
  int         rx_wr     = 0;
  logic [7:0] rx_log_d [0:1023];
  logic       rx_log_f [0:1023];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log_d[rx_wr % 1024] = rx_data;
      rx_log_f[rx_wr % 1024] = rx_first;
      rx_wr = rx_wr + 1;
    end
    if (start_det) start_cnt = start_cnt + 1;
    if (stop_det) stop_cnt = stop_cnt + 1;
    if (rx_first && !rx_valid) bad_first = bad_first + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  // Eight data bits MSB first, then a released 9th bit whose SDA level is the ACK
  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack = ~sda_bus;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic test_reset();
    reset_n = 1'b1; #1;
    reset_n = 1'b0;
    tick(3);
    n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({start_det, stop_det, rx_first} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {start_det, stop_det, rx_first}); end
    reset_n = 1'b1;
    tick(4);
  endtask

  task automatic test_write_basic();
    logic ack;
    int   rb, sb, pb;
    rb = rx_wr; sb = start_cnt; pb = stop_cnt;
    rx_ready = 1'b1;
    bus_start();
    send_byte(8'h78, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL basic_addr_ack: got %b want 1", ack); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
    send_byte(8'h00, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL basic_d0_ack: got %b want 1", ack); end
    send_byte(8'hAF, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL basic_d1_ack: got %b want 1", ack); end
    bus_stop();
    tick(2 * Q);
    n_cmp++; if (rx_wr - rb !== 2) begin n_err++; $display("FAIL basic_rx_count: got %0d want 2", rx_wr - rb); end
    if (rx_wr - rb == 2) begin
      n_cmp++; if ({rx_log_f[rb % 1024], rx_log_d[rb % 1024]} !== {1'b1, 8'h00})
        begin n_err++; $display("FAIL basic_rx0: got first=%b data=%h want first=1 data=00", rx_log_f[rb % 1024], rx_log_d[rb % 1024]); end
      n_cmp++; if ({rx_log_f[(rb + 1) % 1024], rx_log_d[(rb + 1) % 1024]} !== {1'b0, 8'hAF})
        begin n_err++; $display("FAIL basic_rx1: got first=%b data=%h want first=0 data=af", rx_log_f[(rb + 1) % 1024], rx_log_d[(rb + 1) % 1024]); end
    end
    n_cmp++; if (start_cnt - sb !== 1) begin n_err++; $display("FAIL basic_start_cnt: got %0d want 1", start_cnt - sb); end
    n_cmp++; if (stop_cnt - pb !== 1) begin n_err++; $display("FAIL basic_stop_cnt: got %0d want 1", stop_cnt - pb); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_wrong_addr();
    logic ack;
    int   rb;
    rb = rx_wr;
    rx_ready = 1'b1;
    bus_start();
    send_byte(8'h7A, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL wrong_addr_ack: got %b want 0", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wrong_addr_busy: got %b want 0", busy); end
    send_byte(8'h55, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL wrong_addr_data_ack: got %b want 0", ack); end
    bus_stop();
    tick(2 * Q);
    n_cmp++; if (rx_wr - rb !== 0) begin n_err++; $display("FAIL wrong_addr_rx: got %0d want 0", rx_wr - rb); end
  endtask

  task automatic test_read_nack();
    logic ack;
    int   rb;
    rb = rx_wr;
    rx_ready = 1'b1;
    bus_start();
    send_byte(8'h79, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL read_addr_ack: got %b want 0", ack); end
    send_byte(8'hA5, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL read_data_ack: got %b want 0", ack); end
    bus_stop();
    tick(2 * Q);
    n_cmp++; if (rx_wr - rb !== 0) begin n_err++; $display("FAIL read_rx: got %0d want 0", rx_wr - rb); end
  endtask

  task automatic test_not_ready();
    logic ack;
    int   rb;
    rb = rx_wr;
    rx_ready = 1'b1;
    bus_start();
    send_byte(8'h78, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL nready_addr_ack: got %b want 1", ack); end
    rx_ready = 1'b0;
    send_byte(8'h12, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL nready_d0_ack: got %b want 0", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL nready_busy: got %b want 0", busy); end
    rx_ready = 1'b1;
    send_byte(8'h34, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL nready_d1_ack: got %b want 0", ack); end
    bus_stop();
    tick(2 * Q);
    n_cmp++; if (rx_wr - rb !== 0) begin n_err++; $display("FAIL nready_rx: got %0d want 0", rx_wr - rb); end
  endtask

  task automatic test_repeated_start();
    logic       ack;
    logic [7:0] part;
    int         rb, sb;
    rb = rx_wr; sb = start_cnt;
    part = 8'($urandom);
    rx_ready = 1'b1;
    bus_start();
    send_byte(8'h78, ack);
    for (int i = 7; i >= 4; i--) send_bit(part[i]);
    bus_start();
    send_byte(8'h78, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL rstart_addr_ack: got %b want 1", ack); end
    send_byte(8'hC3, ack);
    bus_stop();
    tick(2 * Q);
    n_cmp++; if (start_cnt - sb !== 2) begin n_err++; $display("FAIL rstart_start_cnt: got %0d want 2", start_cnt - sb); end
    n_cmp++; if (rx_wr - rb !== 1) begin n_err++; $display("FAIL rstart_rx_count: got %0d want 1", rx_wr - rb); end
    if (rx_wr - rb == 1) begin
      n_cmp++; if ({rx_log_f[rb % 1024], rx_log_d[rb % 1024]} !== {1'b1, 8'hC3})
        begin n_err++; $display("FAIL rstart_rx: got first=%b data=%h want first=1 data=c3", rx_log_f[rb % 1024], rx_log_d[rb % 1024]); end
    end
  endtask

  task automatic test_reset_mid_ack();
    logic [7:0] a;
    a = 8'h78;
    rx_ready = 1'b1;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    sda_m = 1'b1; tick(Q);
    n_cmp++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL midack_oe_before: got %b want 1", sda_oe); end
    scl_m = 1'b1; tick(1);
    reset_n = 1'b0; #1;
    n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL midack_oe_reset: got %b want 0", sda_oe); end
    n_cmp++; if ({busy, rx_valid, rx_first, start_det, stop_det, rx_data} !== 13'h0)
      begin n_err++; $display("FAIL midack_outputs: got %h want 0", {busy, rx_valid, rx_first, start_det, stop_det, rx_data}); end
    tick(2);
    reset_n = 1'b1;
    scl_m = 1'b0; tick(Q);
    bus_stop();
    tick(2 * Q);
  endtask

  // Random transactions against a byte-level model of ACK and delivery
  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] exp_d [0:3];
      logic       exp_f [0:3];
      logic       ack, exp_ack, accepting, first, rdy;
      int         nb, exp_n, rb;
      a  = ($urandom_range(0, 1) != 0) ? 8'h78 : 8'($urandom);
      nb = int'($urandom_range(1, 4));
      rb = rx_wr;
      exp_n = 0;
      first = 1'b1;
      accepting = (a[7:1] == 7'h3C) && (a[0] == 1'b0);
      rx_ready = 1'b1;
      bus_start();
      send_byte(a, ack);
      n_cmp++; if (ack !== accepting) begin n_err++; $display("FAIL rand_addr_ack t=%0d a=%h: got %b want %b", t, a, ack, accepting); end
      for (int i = 0; i < nb; i++) begin
        d   = 8'($urandom);
        rdy = ($urandom_range(0, 3) != 0);
        rx_ready = rdy;
        exp_ack = accepting && rdy;
        send_byte(d, ack);
        n_cmp++; if (ack !== exp_ack) begin n_err++; $display("FAIL rand_data_ack t=%0d i=%0d: got %b want %b", t, i, ack, exp_ack); end
        if (exp_ack) begin
          exp_d[exp_n] = d;
          exp_f[exp_n] = first;
          exp_n = exp_n + 1;
          first = 1'b0;
        end else begin
          accepting = 1'b0;
        end
      end
      rx_ready = 1'b1;
      bus_stop();
      tick(2 * Q);
      n_cmp++; if (rx_wr - rb !== exp_n) begin n_err++; $display("FAIL rand_rx_count t=%0d: got %0d want %0d", t, rx_wr - rb, exp_n); end
      if (rx_wr - rb == exp_n) begin
        for (int k = 0; k < exp_n; k++) begin
          n_cmp++;
          if ({rx_log_f[(rb + k) % 1024], rx_log_d[(rb + k) % 1024]} !== {exp_f[k], exp_d[k]}) begin
            n_err++;
            $display("FAIL rand_rx t=%0d k=%0d: got first=%b data=%h want first=%b data=%h",
                     t, k, rx_log_f[(rb + k) % 1024], rx_log_d[(rb + k) % 1024], exp_f[k], exp_d[k]);
          end
        end
      end
    end
  endtask

`ifdef I2C_TARGET_DEGLITCH_EN
  task automatic test_glitch();
    int sb, pb;
    sb = start_cnt; pb = stop_cnt;
    // SDA dips for one clk with SCL high on an idle bus
    sda_m = 1'b0; tick(1);
    sda_m = 1'b1; tick(20);
    n_cmp++; if (start_cnt - sb !== 0) begin n_err++; $display("FAIL glitch_start: got %0d want 0", start_cnt - sb); end
    // SDA low with SCL high, then a one-clk high spike
    scl_m = 1'b0; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(3 * Q);
    sda_m = 1'b1; tick(1);
    sda_m = 1'b0; tick(20);
    n_cmp++; if (stop_cnt - pb !== 0) begin n_err++; $display("FAIL glitch_stop: got %0d want 0", stop_cnt - pb); end
    sda_m = 1'b1; tick(4 * Q);
  endtask
`endif

  initial begin
    reset_n  = 1'b1;
    scl_m    = 1'b1;
    sda_m    = 1'b1;
    rx_ready = 1'b1;
    test_reset();
    test_write_basic();
    test_wrong_addr();
    test_read_nack();
    test_not_ready();
    test_repeated_start();
    test_reset_mid_ack();
`ifdef I2C_TARGET_DEGLITCH_EN
    test_glitch();
`endif
    test_random(25);
    n_cmp++; if (bad_first !== 0) begin n_err++; $display("FAIL rx_first_without_valid: got %0d want 0", bad_first); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
